// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a DEPTH-word memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one burst each.
// Ports:
//   aclk, areset_n          clock, async active-low reset
//   aw*/awready             write address channel
//   w*/wready               write data channel
//   b*/bready               write response channel
//   ar*/arready             read address channel
//   r*/rready               read data channel
// Build option: define AXI_SLAVE_MEM_WRAP_EN to support WRAP bursts.
// Without it, burst type 2'b10 is answered with SLVERR.
module axi_slave_mem #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * STRB_W);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;

    logic [ADDR_W-1:0] w_addr, w_addr_n, w_step;
    logic [7:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [1:0]        w_err;
    logic              w_lerr;

    logic [ADDR_W-1:0] r_addr, r_addr_n, r_step;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

`ifdef AXI_SLAVE_MEM_WRAP_EN
    logic [ADDR_W-1:0] w_wmask, r_wmask;
`endif

    logic [1:0] aw_resp, ar_resp;
    logic       aw_hs, ar_hs, w_hs, w_fin, w_lbad, r_hs;

    assign aw_hs  = awvalid && awready;
    assign ar_hs  = arvalid && arready;
    assign w_hs   = wvalid && wready;
    assign w_fin  = w_hs && (w_cnt == 8'd0);
    assign w_lbad = wlast != (w_cnt == 8'd0);
    assign r_hs   = rvalid && rready;

    // Whole-burst response, decided once at the address handshake.
    always_comb begin
        aw_resp = OKAY;
        if ({1'b0, awaddr} >= MEM_BYTES)
            aw_resp = DECERR;
        else if (awburst == 2'b11 || (32'd1 << awsize) > 32'(STRB_W))
            aw_resp = SLVERR;
`ifdef AXI_SLAVE_MEM_WRAP_EN
        else if (awburst == 2'b10 &&
                 !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
            aw_resp = SLVERR;
`else
        else if (awburst == 2'b10)
            aw_resp = SLVERR;
`endif
    end

    always_comb begin
        ar_resp = OKAY;
        if ({1'b0, araddr} >= MEM_BYTES)
            ar_resp = DECERR;
        else if (arburst == 2'b11 || (32'd1 << arsize) > 32'(STRB_W))
            ar_resp = SLVERR;
`ifdef AXI_SLAVE_MEM_WRAP_EN
        else if (arburst == 2'b10 &&
                 !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
            ar_resp = SLVERR;
`else
        else if (arburst == 2'b10)
            ar_resp = SLVERR;
`endif
    end

    // Next beat address; WRAP keeps the upper bits and wraps the low ones.
    always_comb begin
        w_step   = ADDR_W'(1) << w_size;
        w_addr_n = w_addr;
        if (w_burst == 2'b01)
            w_addr_n = w_addr + w_step;
`ifdef AXI_SLAVE_MEM_WRAP_EN
        else if (w_burst == 2'b10)
            w_addr_n = (w_addr & ~w_wmask) | ((w_addr + w_step) & w_wmask);
`endif
    end

    always_comb begin
        r_step   = ADDR_W'(1) << r_size;
        r_addr_n = r_addr;
        if (r_burst == 2'b01)
            r_addr_n = r_addr + r_step;
`ifdef AXI_SLAVE_MEM_WRAP_EN
        else if (r_burst == 2'b10)
            r_addr_n = (r_addr & ~r_wmask) | ((r_addr + r_step) & r_wmask);
`endif
    end

    // Write FSM
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)
            w_state <= W_IDLE;
        else
            w_state <= w_state_n;
    end

    always_comb begin
        w_state_n = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_n = W_DATA;
            W_DATA:  if (w_fin) w_state_n = W_RESP;
            W_RESP:  if (bvalid && bready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= OKAY;
            w_addr  <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= OKAY;
            w_lerr  <= 1'b0;
`ifdef AXI_SLAVE_MEM_WRAP_EN
            w_wmask <= '0;
`endif
        end else begin
            awready <= (w_state_n == W_IDLE);
            wready  <= (w_state_n == W_DATA);
            bvalid  <= (w_state_n == W_RESP);
            if (aw_hs) begin
                bid     <= awid;
                w_addr  <= awaddr;
                w_cnt   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_err   <= aw_resp;
                w_lerr  <= 1'b0;
`ifdef AXI_SLAVE_MEM_WRAP_EN
                w_wmask <= ((ADDR_W'(awlen) + ADDR_W'(1)) << awsize)
                           - ADDR_W'(1);
`endif
            end
            if (w_hs) begin
                w_addr <= w_addr_n;
                w_cnt  <= w_cnt - 8'd1;
                if (w_lbad)
                    w_lerr <= 1'b1;
                // A misplaced wlast on any beat overrides the response.
                if (w_fin)
                    bresp <= (w_lbad || w_lerr) ? SLVERR : w_err;
            end
        end
    end

    // Memory is never reset; only error-free bursts write.
    always_ff @(posedge aclk) begin
        if (w_hs && w_err == OKAY) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b])
                    mem[w_addr[OFF_W +: IDX_W]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Read FSM
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)
            r_state <= R_IDLE;
        else
            r_state <= r_state_n;
    end

    always_comb begin
        r_state_n = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_n = R_DATA;
            R_DATA:  if (r_hs && rlast) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    // rdata is fetched one beat ahead so it is ready with rvalid;
    // a same-cycle write lands after this read and is not seen.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
`ifdef AXI_SLAVE_MEM_WRAP_EN
            r_wmask <= '0;
`endif
        end else begin
            arready <= (r_state_n == R_IDLE);
            rvalid  <= (r_state_n == R_DATA);
            if (ar_hs) begin
                rid     <= arid;
                rresp   <= ar_resp;
                rlast   <= (arlen == 8'd0);
                r_cnt   <= arlen;
                r_addr  <= araddr;
                r_size  <= arsize;
                r_burst <= arburst;
`ifdef AXI_SLAVE_MEM_WRAP_EN
                r_wmask <= ((ADDR_W'(arlen) + ADDR_W'(1)) << arsize)
                           - ADDR_W'(1);
`endif
                rdata   <= (ar_resp == OKAY) ?
                           mem[araddr[OFF_W +: IDX_W]] : '0;
            end else if (r_hs && !rlast) begin
                r_addr <= r_addr_n;
                r_cnt  <= r_cnt - 8'd1;
                rlast  <= (r_cnt == 8'd1);
                rdata  <= (rresp == OKAY) ?
                          mem[r_addr_n[OFF_W +: IDX_W]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized scoreboard bench for axi_slave_mem.
// Reference model is a word array plus burst address arithmetic.
module tb_axi_slave_mem;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int MEMB   = DEPTH * 4;

    logic              aclk;
    logic              areset_n;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    axi_slave_mem #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    bexp_t bq[$];
    rexp_t rq[$];
    bexp_t be;
    rexp_t re;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    function automatic logic [1:0] exp_resp(input longint unsigned a,
                                            input int len, input int size,
                                            input int burst);
        bit wrap_legal;
        wrap_legal = (len == 1 || len == 3 || len == 7 || len == 15);
`ifndef AXI_SLAVE_MEM_WRAP_EN
        wrap_legal = 1'b0;
`endif
        if (a >= longint'(MEMB)) return 2'b11;
        if (burst == 3 || (1 << size) > 4) return 2'b10;
        if (burst == 2 && !wrap_legal) return 2'b10;
        return 2'b00;
    endfunction

    function automatic longint unsigned beat_addr(input longint unsigned s,
                                                  input int len, input int size,
                                                  input int burst, input int i);
        longint unsigned st, w, base;
        st = 64'd1 << size;
        if (burst == 0) return s;
        if (burst == 2) begin
            w    = longint'(len + 1) * st;
            base = s - (s % w);
            return base + ((s - base) + longint'(i) * st) % w;
        end
        return s + longint'(i) * st;
    endfunction

    function automatic int widx(input longint unsigned a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Monitor: compares DUT responses against the scoreboard queues.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else begin
                    be = bq.pop_front();
                    chk("bid", 64'(bid), 64'(be.id));
                    chk("bresp", 64'(bresp), 64'(be.resp));
                end
            end
            if (rvalid) begin
                if (rq.size() == 0) fail("r_unexpected");
                else begin
                    re = rq[0];
                    chk("rdata", 64'(rdata), 64'(re.data));
                    chk("rresp", 64'(rresp), 64'(re.resp));
                    chk("rlast", 64'(rlast), 64'(re.last));
                    chk("rid", 64'(rid), 64'(re.id));
                    if (rready) re = rq.pop_front();
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge aclk);
        #2 areset_n = 1'b0;
        #1;
        chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_bvalid", 64'(bvalid), 0);
        chk("rst_awready", 64'(awready), 0);
        chk("rst_arready", 64'(arready), 0);
        chk("rst_wready", 64'(wready), 0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        bq.delete();
        rq.delete();
        repeat (2) @(posedge aclk);
        #2;
        chk("rst_hold_arready", 64'(arready), 0);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst_awready", 64'(awready), 1);
        chk("post_rst_arready", 64'(arready), 1);
    endtask

    task automatic do_write(input logic [3:0] id, input longint unsigned addr,
                            input int len, input int size, input int burst,
                            input int bad_last, input int abort_after);
        logic [1:0] base;
        logic [1:0] rsp;
        bit ok;
        int n;
        int k;
        longint unsigned a;
        base = exp_resp(addr, len, size, burst);
        rsp  = (bad_last >= 0) ? 2'b10 : base;
        if (abort_after < 0) bq.push_back('{id: id, resp: rsp});
        awid = id; awaddr = 32'(addr); awlen = 8'(len);
        awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = awready; @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        awvalid = 1'b0;
        if (!ok) begin fail("aw_timeout"); return; end
        for (int i = 0; i <= len; i++) begin
            if (i == abort_after) begin
                wvalid = 1'b0;
                pulse_reset();
                return;
            end
            if ($urandom % 4 == 0) begin
                wvalid = 1'b0; @(posedge aclk); #1;
            end
            wdata = wdat[i]; wstrb = wstb[i];
            wlast = (i == len) ^ (i == bad_last);
            wvalid = 1'b1;
            n = 0;
            do begin
                @(negedge aclk); ok = wready; @(posedge aclk); #1; n++;
            end while (!ok && n < 50);
            if (!ok) begin fail("w_timeout"); wvalid = 1'b0; return; end
            if (base == 2'b00) begin
                a = beat_addr(addr, len, size, burst, i);
                k = widx(a);
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[k][8*b +: 8] = wdat[i][8*b +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 100) begin
            bready = 1'($urandom % 2); @(posedge aclk); #1; n++;
        end
        bready = 1'b0;
        if (bq.size() != 0) begin fail("b_timeout"); bq.delete(); end
        chk("b_done_bvalid", 64'(bvalid), 0);
    endtask

    // mode 0: rready always 1; 1: 1,0,0 repeating; 2: random.
    task automatic do_read(input logic [3:0] id, input longint unsigned addr,
                           input int len, input int size, input int burst,
                           input int mode, input int abort_at);
        logic [1:0] rsp;
        bit ok;
        bit aborted;
        int n;
        longint unsigned a;
        rsp = exp_resp(addr, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            rq.push_back('{id: id,
                           data: (rsp == 2'b00) ? mdl[widx(a)] : 32'h0,
                           resp: rsp, last: (i == len)});
        end
        rready = 1'b0;
        arid = id; araddr = 32'(addr); arlen = 8'(len);
        arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = arready; @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        arvalid = 1'b0;
        if (!ok) begin fail("ar_timeout"); rq.delete(); return; end
        chk("r_first_latency", 64'(rvalid), 1);
        n = 0;
        aborted = 1'b0;
        while (rq.size() != 0 && n < 400) begin
            if (n == abort_at) begin aborted = 1'b1; break; end
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (n % 3 == 0);
                default: rready = 1'($urandom % 2);
            endcase
            @(posedge aclk); #1; n++;
        end
        rready = 1'b0;
        if (aborted) begin
            pulse_reset();
            return;
        end
        if (rq.size() != 0) begin fail("r_timeout"); rq.delete(); end
        chk("r_done_rvalid", 64'(rvalid), 0);
    endtask

    initial begin
        int op;
        int burst;
        int size;
        int len;
        longint unsigned addr;
        areset_n = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; bready = 1'b0; arid = '0; araddr = '0;
        arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        #3 areset_n = 1'b0;
        #1;
        chk("init_awready", 64'(awready), 0);
        chk("init_arready", 64'(arready), 0);
        chk("init_bvalid", 64'(bvalid), 0);
        chk("init_rvalid", 64'(rvalid), 0);
        chk("init_rdata", 64'(rdata), 0);
        repeat (3) @(posedge aclk);
        #2 areset_n = 1'b1;
        @(posedge aclk); #1;
        chk("rel_awready", 64'(awready), 1);
        chk("rel_arready", 64'(arready), 1);

        for (int i = 0; i < DEPTH; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        do_write(4'd1, 0, DEPTH - 1, 2, 1, -1, -1);

        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
        do_write(4'd5, 'h10, 3, 2, 1, -1, -1);
        do_read(4'd6, 'h10, 3, 2, 1, 0, -1);

        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        do_write(4'd2, 0, 0, 2, 1, -1, -1);
        wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
        do_write(4'd3, 0, 0, 2, 1, -1, -1);
        do_read(4'd4, 0, 0, 2, 1, 0, -1);

        do_read(4'd3, 'h18, 3, 2, 2, 0, -1);

        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(4'd2, MEMB, 0, 2, 1, -1, -1);
        do_read(4'd2, 0, 0, 2, 1, 0, -1);
        wdat[0] = 32'h01010101; wdat[1] = 32'h02020202;
        wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(4'd4, 'h40, 1, 2, 1, 0, -1);
        do_read(4'd4, 'h40, 1, 2, 1, 2, -1);

        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        do_write(4'd7, (DEPTH - 2) * 4, 3, 2, 1, -1, -1);
        do_read(4'd7, (DEPTH - 2) * 4, 3, 2, 1, 0, -1);

        do_read(4'd8, 'h20, 7, 2, 1, 1, -1);
        do_read(4'd9, 0, 7, 2, 1, 0, 3);

        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        do_write(4'd10, 'h80, 3, 2, 1, -1, 2);
        do_read(4'd11, 'h80, 3, 2, 1, 0, -1);

        for (int t = 0; t < 40; t++) begin
            op = $urandom % 2;
            case ($urandom % 8)
                0:       burst = 0;
                5, 6:    burst = 2;
                7:       burst = 3;
                default: burst = 1;
            endcase
            size = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            if (burst == 2 && $urandom % 5 != 0)
                len = (2 << ($urandom % 4)) - 1;
            else
                len = int'($urandom % 8);
            if ($urandom % 8 == 0)
                addr = MEMB + ($urandom % 64);
            else
                addr = $urandom % MEMB;
            if (size < 3) addr = addr & ~((64'd1 << size) - 1);
            if (op == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wdat[i] = $urandom; wstb[i] = 4'($urandom);
                end
                do_write(4'($urandom), addr, len, size, burst, -1, -1);
            end else begin
                do_read(4'($urandom), addr, len, size, burst, 2, -1);
            end
        end

        repeat (2) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
